lcd_spi_ctrl: RTL
=================

// Module: lcd_spi_ctrl
// PURPOSE
//  Memory-mapped write-only SPI master driving the ILI9341 LCD pins (LCD_DCX/SDO/SCK/CSX) of HACK.
//  The CPU writes command/data bytes (LCD8 @ 4104) or 16-bit pixel words (LCD16 @ 4105) through
//  Memory loadIO8/loadIO9 with outM, and polls busy on the shared read port.
//  Sits directly downstream of the HACK memory map, alongside the UART and flash SPI peripherals.
// PARAMETERS
//  CLK_DIV  1  clk cycles per SCK half-period (1 -> 12.5 MHz SCK at 25 MHz clk); legal 1..255
// PORTS
//  clk     in   1   internal 25 MHz system clock
//  resetx  in   1   asynchronous reset, active low
//  load8   in   1   1-cycle strobe: byte/command write (LCD8)
//  load16  in   1   1-cycle strobe: 16-bit pixel write (LCD16)
//  in      in   16  outM write data
//  out     out  16  status read: [15]=busy, [14:0]=0
//  DCX     out  1   LCD data/command-not
//  SDO     out  1   serial data out (MOSI)
//  SCK     out  1   serial clock
//  CSX     out  1   chip select, active low
// BEHAVIOUR
//  Reset (async, resetx=0): state=IDLE, CSX=1, SCK=0, SDO=0, DCX=0, out=0, bit counter=0, divider=0.
//  Register decode at accept, IDLE only:
//   load8:  in[9]=1 -> release: CSX<=1 next cycle, nothing sent, busy stays 0.
//           in[9]=0 -> send 8 bits in[7:0] MSB first, DCX<=in[8].
//   load16: send 16 bits in[15:0] MSB first, DCX<=1.
//   load8 and load16 in the same cycle -> load16 wins; load8 dropped.
//  Strobes while busy (either port) are ignored: no queueing, no state change.
//  FSM: IDLE -> LOW -> HIGH -> (LOW | IDLE).
//   Accept edge: CSX<=0, DCX set, SDO<=MSB, SCK=0, out[15]<=1, N=8|16 loaded, state=LOW.
//   LOW:  SCK=0 for CLK_DIV cycles -> SCK<=1, state=HIGH (slave samples SDO on rising edge, mode 0).
//   HIGH: SCK=1 for CLK_DIV cycles -> SCK<=0; last bit -> state=IDLE, busy<=0;
//         else SDO<=next bit, state=LOW.
//  SDO changes only on falling SCK edges or at accept; it holds the last bit value after the transfer.
//  Transfer latency: busy high exactly 2*CLK_DIV*N cycles, from the cycle after the strobe.
//  A new strobe is accepted in the first cycle busy reads 0.
//  CSX stays low between transfers and rises only on a release write or reset; DCX holds its last value.
//  Divider: 8-bit down-counter reloaded with CLK_DIV-1 at each phase change.
//  Bit counter: 5-bit, counts down from N; no wrap past 0.
//  Reset asserted mid-transfer aborts immediately: all outputs return to reset values, no partial state kept.
//  out is registered, combinationally independent of in/load.
// TESTING
//  1 reset; load8 in=0x0036 (CLK_DIV=1) -> CSX=0, DCX=0, SDO 0,0,1,1,0,1,1,0 on 8 SCK rises, busy 16 cycles.
//  2 load16 in=0xF800 -> DCX=1, 16 SCK rises, SDO 1111100000000000, busy 32 cycles; CSX still 0 after.
//  3 load8 in=0x0200 (release) when idle -> CSX=1 next cycle, no SCK edge, out=0x0000 throughout.
//  4 load8 0x012C, then load16 0x1234 at busy cycle 5 -> second ignored; only 8 bits sent with DCX=1.
//  5 CLK_DIV=4, load8 0x00A5 -> SCK half-periods of 4 clk, busy=64 cycles, bits 10100101.
//  6 resetx low at bit 3 of a load16 -> CSX=1, SCK=0, SDO=0, out=0 same edge; next load8 sends a clean 8 bits.

Source files
------------

// File: rtl/lcd_spi_ctrl.sv
// rtl/lcd_spi_ctrl.sv - write-only SPI master for the ILI9341 LCD (byte/command and 16-bit pixel writes)
module lcd_spi_ctrl #(
   parameter int CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        resetx,
   input  logic        load8,
   input  logic        load16,
   input  logic [15:0] in,
   output logic [15:0] out,
   output logic        DCX,
   output logic        SDO,
   output logic        SCK,
   output logic        CSX
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

   state_t      state, state_nxt;
   logic [7:0]  div;
   logic [4:0]  bit_cnt;
   logic [15:0] shreg;
   logic        busy;
   logic        accept16, accept8, release_cs, phase_done, last_bit;

   always_comb begin
      accept16   = 1'b0;
      accept8    = 1'b0;
      release_cs = 1'b0;
      phase_done = (div == 8'd0);
      last_bit   = (bit_cnt == 5'd1);
      state_nxt  = state;
      case (state)
         IDLE: begin
            // load16 has priority when both strobes arrive together
            accept16   = load16;
            accept8    = load8 & ~load16 & ~in[9];
            release_cs = load8 & ~load16 & in[9];
            if (accept16 || accept8)
               state_nxt = LOW;
         end
         LOW: begin
            if (phase_done)
               state_nxt = HIGH;
         end
         HIGH: begin
            if (phase_done)
               state_nxt = last_bit ? IDLE : LOW;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetx) begin
      if (!resetx)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge resetx) begin
      if (!resetx) begin
         CSX     <= 1'b1;
         SCK     <= 1'b0;
         SDO     <= 1'b0;
         DCX     <= 1'b0;
         busy    <= 1'b0;
         bit_cnt <= 5'd0;
         div     <= 8'd0;
         shreg   <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept16) begin
                  CSX     <= 1'b0;
                  DCX     <= 1'b1;
                  shreg   <= in;
                  SDO     <= in[15];
                  bit_cnt <= 5'd16;
                  div     <= DIV_RELOAD;
                  busy    <= 1'b1;
               end else if (accept8) begin
                  CSX     <= 1'b0;
                  DCX     <= in[8];
                  shreg   <= {in[7:0], 8'h00};
                  SDO     <= in[7];
                  bit_cnt <= 5'd8;
                  div     <= DIV_RELOAD;
                  busy    <= 1'b1;
               end else if (release_cs) begin
                  CSX <= 1'b1;
               end
            end
            LOW: begin
               if (phase_done) begin
                  SCK <= 1'b1;
                  div <= DIV_RELOAD;
               end else begin
                  div <= div - 8'd1;
               end
            end
            HIGH: begin
               if (phase_done) begin
                  SCK <= 1'b0;
                  div <= DIV_RELOAD;
                  if (last_bit) begin
                     busy    <= 1'b0;
                     bit_cnt <= 5'd0;
                  end else begin
                     // next bit goes out on the falling edge so it is stable for the next rise
                     bit_cnt <= bit_cnt - 5'd1;
                     shreg   <= {shreg[14:0], 1'b0};
                     SDO     <= shreg[14];
                  end
               end else begin
                  div <= div - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign out = {busy, 15'd0};

endmodule
